// File: rtl/stream_mux.sv
// stream_mux: N-input, WIDTH-bit valid/ready stream multiplexer with a registered output stage.
//
// Arbitration is either software-directed (mode = 0, channel chosen by sel) or round-robin
// (mode = 1, scan starts at an internal pointer that advances past each round-robin winner).
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used in fixed mode (values >= N grant nothing)
//   in_valid   per-channel valid
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel ready, combinational, at most one bit set
//   out_valid  output register holds a word
//   out_data   registered data
//   out_src    channel index that supplied out_data
//   out_ready  consumer accepts out_data this cycle
module stream_mux #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 8,
    parameter int unsigned SW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_src,
    input  logic                 out_ready
);

    // Channel index (base + off) wrapped into 0..N-1; base is always < N.
    function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return SW'(sum);
    endfunction

    logic             load_en;
    logic             fix_valid;
    logic             rr_valid;
    logic [SW-1:0]    rr_grant;
    logic             grant_valid;
    logic [SW-1:0]    grant;
    logic [WIDTH-1:0] grant_data;
    logic             transfer;
    logic [SW-1:0]    ptr_q;
    logic [SW-1:0]    ptr_d;

    // rst_n is folded in so in_ready stays low for the whole reset interval.
    assign load_en = rst_n & (~out_valid | out_ready);

    // Fixed select: an out-of-range sel matches no channel, so it grants nothing.
    always_comb begin
        fix_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                fix_valid = in_valid[i];
            end
        end
    end

    // Round-robin: first valid channel at or after ptr, wrapping at N.
    always_comb begin
        rr_valid = 1'b0;
        rr_grant = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!rr_valid && in_valid[rr_index(ptr_q, k)]) begin
                rr_valid = 1'b1;
                rr_grant = rr_index(ptr_q, k);
            end
        end
    end

    assign grant_valid = mode ? rr_valid : fix_valid;
    assign grant       = mode ? rr_grant : sel;
    assign transfer    = load_en & grant_valid;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SW'(i)) begin
                in_ready[i] = transfer;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves only on round-robin transfers; fixed-mode traffic leaves it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (transfer && mode) begin
            ptr_d = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_src   <= grant;
            end else if (load_en) begin
                // Word drained with nothing to replace it; data and src keep last values.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: checks stream_mux at N = 8 and N = 5 (WIDTH = 16) side by side against a
// behavioural model of the grant rules, output register and round-robin pointer.
module tb_stream_mux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [2:0]   sel;
    logic [7:0]   in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic [7:0]   in_ready8;
    logic         ov8;
    logic [15:0]  od8;
    logic [2:0]   os8;
    logic [4:0]   in_ready5;
    logic         ov5;
    logic [15:0]  od5;
    logic [2:0]   os5;

    int total = 0;
    int bad   = 0;

    // Model state per instance: index 0 is N = 8, index 1 is N = 5.
    int nch[2] = '{8, 5};
    int mv[2];
    int md[2];
    int ms[2];
    int mp[2];

    always #5 clk = ~clk;

    stream_mux #(.WIDTH(16), .N(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready8),
        .out_valid (ov8),
        .out_data  (od8),
        .out_src   (os8),
        .out_ready (out_ready)
    );

    stream_mux #(.WIDTH(16), .N(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid[4:0]),
        .in_data   (in_data[79:0]),
        .in_ready  (in_ready5),
        .out_valid (ov5),
        .out_data  (od5),
        .out_src   (os5),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winning channel under the arbitration rules, or -1 when nothing is granted.
    function automatic int pick(int n, int ptr, logic m, logic [2:0] s, logic [7:0] v);
        if (!m) begin
            if (int'(s) < n && v[s]) return int'(s);
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            mv[j] = 0;
            md[j] = 0;
            ms[j] = 0;
            mp[j] = 0;
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) begin
            in_data[i*16 +: 16] = 16'($urandom);
        end
    endtask

    // One clock cycle: check ready before the edge, advance the model, check registers after.
    task automatic cyc();
        int         g[2];
        logic [7:0] er[2];
        #1;
        for (int j = 0; j < 2; j++) begin
            g[j] = pick(nch[j], mp[j], mode, sel, in_valid);
            er[j] = (rst_n && (mv[j] == 0 || out_ready) && g[j] >= 0) ? (8'd1 << g[j]) : 8'd0;
        end
        chk("ready8", 32'(in_ready8), 32'(er[0]));
        chk("ready5", 32'(in_ready5), 32'(er[1]));
        @(posedge clk);
        for (int j = 0; j < 2; j++) begin
            if (er[j] != 8'd0) begin
                mv[j] = 1;
                md[j] = int'(in_data[g[j]*16 +: 16]);
                ms[j] = g[j];
                if (mode) mp[j] = (g[j] + 1) % nch[j];
            end else if (mv[j] == 0 || out_ready) begin
                mv[j] = 0;
            end
        end
        #1;
        chk("out_valid8", 32'(ov8), mv[0]);
        chk("out_data8", 32'(od8), md[0]);
        chk("out_src8", 32'(os8), ms[0]);
        chk("out_valid5", 32'(ov5), mv[1]);
        chk("out_data5", 32'(od5), md[1]);
        chk("out_src5", 32'(os5), ms[1]);
    endtask

    initial begin
        // Reset held with every channel requesting.
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 3'd0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        rand_data();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready8", 32'(in_ready8), 32'h0);
        chk("rst_ready5", 32'(in_ready5), 32'h0);
        chk("rst_valid8", 32'(ov8), 32'h0);
        chk("rst_data8", 32'(od8), 32'h0);
        chk("rst_src8", 32'(os8), 32'h0);
        chk("rst_valid5", 32'(ov5), 32'h0);
        rst_n = 1'b1;

        // Fixed select of channel 5; N = 5 sees sel out of range.
        sel = 3'd5;
        rand_data();
        in_data[5*16 +: 16] = 16'hBEEF;
        #1;
        chk("fix_ready8", 32'(in_ready8), 32'h20);
        chk("fix_ready5", 32'(in_ready5), 32'h0);
        cyc();
        chk("fix_data8", 32'(od8), 32'hBEEF);
        chk("fix_src8", 32'(os8), 32'd5);

        // Selected channel idle, then drain.
        sel      = 3'd6;
        in_valid = 8'hBF;
        #1;
        chk("idle_ready8", 32'(in_ready8), 32'h0);
        chk("sel6_ready5", 32'(in_ready5), 32'h0);
        cyc();
        chk("drain_valid8", 32'(ov8), 32'h0);

        // Round-robin fairness, everything requesting.
        mode     = 1'b1;
        in_valid = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            cyc();
            chk("rr_src8", 32'(os8), i % 8);
            chk("rr_valid8", 32'(ov8), 32'h1);
            chk("rr_src5", 32'(os5), i % 5);
        end

        // Round-robin skip: park ptr at 3, then channels 2 and 7 compete.
        in_valid = 8'b0000_0100;
        cyc();
        in_valid = 8'b1000_0100;
        rand_data();
        cyc();
        chk("skip_a", 32'(os8), 32'd7);
        rand_data();
        cyc();
        chk("skip_b", 32'(os8), 32'd2);
        rand_data();
        cyc();
        chk("skip_c", 32'(os8), 32'd7);

        // Backpressure with the output full, then pass-through on release.
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cyc();
            chk("bp_src8", 32'(os8), 32'd7);
            chk("bp_ready8", 32'(in_ready8), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("pass_ready8", 32'(in_ready8), 32'h01);
        cyc();
        chk("pass_src8", 32'(os8), 32'd0);
        chk("pass_valid8", 32'(ov8), 32'h1);

        // N = 5 wrap: park ptr at 4, then channels 0 and 4 compete.
        in_valid = 8'b0000_1000;
        cyc();
        in_valid = 8'b0001_0001;
        cyc();
        chk("wrap5_a", 32'(os5), 32'd4);
        cyc();
        chk("wrap5_b", 32'(os5), 32'd0);
        cyc();
        chk("wrap5_c", 32'(os5), 32'd4);

        // Mode and sel churn during a stall must not disturb the held word.
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            mode = 1'(i);
            sel  = 3'($urandom);
            rand_data();
            cyc();
        end

        // Asynchronous reset while a word is held.
        rst_n = 1'b0;
        #2;
        chk("async_valid8", 32'(ov8), 32'h0);
        chk("async_valid5", 32'(ov5), 32'h0);
        chk("async_data8", 32'(od8), 32'h0);
        chk("async_ready8", 32'(in_ready8), 32'h0);
        model_reset();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom);
            sel       = 3'($urandom);
            in_valid  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
